// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - memory command codes and FSM state encodings
package dmem_access_ctrl_pkg;

    localparam logic [1:0] MEMNOP = 2'b00;
    localparam logic [1:0] MEMWLD = 2'b01;
    localparam logic [1:0] MEMWST = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store sequencer in front of the 256x128 data memory
// Address buses use MSB-first bit naming upstream: bit 0 there is bit [31] here.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [127:0]     req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic [1:0]       dm_ctrl_sig,
    output logic [31:0]      mem_ctrl_addr,
    output logic [127:0]     dm_wdata,
    input  logic [127:0]     dm_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [127:0]     rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             addr_err
);

    function automatic logic addr_in_range(input logic [31:0] a);
        return (a >> IDX_W) == 32'd0;
    endfunction

    state_e             r_state;
    state_e             w_next;
    logic [1:0]         r_dm_ctrl;
    logic [31:0]        r_mem_addr;
    logic [127:0]       r_dm_wdata;
    logic [TAG_W-1:0]   r_tag;
    logic [127:0]       r_rsp_data;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_rsp_err;
    logic               r_addr_err;

    logic w_accept;
    logic w_is_ld;
    logic w_is_st;
    logic w_in_range;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_is_ld    = (req_op == MEMWLD);
    assign w_is_st    = (req_op == MEMWST);
    assign w_in_range = addr_in_range(req_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_ld)
                    w_next = w_in_range ? ST_ISSUE : ST_RESP;
                else if (w_accept && w_is_st && w_in_range)
                    w_next = ST_ISSUE;
            end
            // The registered command still shows which op is in flight.
            ST_ISSUE: w_next = (r_dm_ctrl == MEMWLD) ? ST_WAIT : ST_IDLE;
            ST_WAIT:  w_next = ST_RESP;
            ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dm_ctrl  <= MEMNOP;
            r_mem_addr <= '0;
            r_dm_wdata <= '0;
            r_tag      <= '0;
            r_rsp_data <= '0;
            r_rsp_tag  <= '0;
            r_rsp_err  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_dm_ctrl  <= MEMNOP;
            r_addr_err <= w_accept && (w_is_ld || w_is_st) && !w_in_range;
            if (w_accept && (w_is_ld || w_is_st) && w_in_range) begin
                r_dm_ctrl  <= req_op;
                r_mem_addr <= {req_addr[IDX_W-1:0], {(32-IDX_W){1'b0}}};
                r_dm_wdata <= req_wdata;
                r_tag      <= req_tag;
            end
            if (w_accept && w_is_ld && !w_in_range) begin
                r_rsp_data <= '0;
                r_rsp_tag  <= req_tag;
                r_rsp_err  <= 1'b1;
            end
            if (r_state == ST_WAIT) begin
                r_rsp_data <= dm_rdata;
                r_rsp_tag  <= r_tag;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign rsp_valid     = (r_state == ST_RESP);
    assign dm_ctrl_sig   = r_dm_ctrl;
    assign mem_ctrl_addr = r_mem_addr;
    assign dm_wdata      = r_dm_wdata;
    assign rsp_data      = r_rsp_data;
    assign rsp_tag       = r_rsp_tag;
    assign rsp_err       = r_rsp_err;
    assign addr_err      = r_addr_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] WLD = 2'b01;
    localparam logic [1:0] WST = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = NOP;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [4:0]   req_tag = '0;
    logic [1:0]   dm_ctrl_sig;
    logic [31:0]  mem_ctrl_addr;
    logic [127:0] dm_wdata;
    logic [127:0] dm_rdata = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic [4:0]   rsp_tag;
    logic         rsp_err;
    logic         addr_err;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_access_ctrl #(.IDX_W(8), .TAG_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .dm_ctrl_sig(dm_ctrl_sig), .mem_ctrl_addr(mem_ctrl_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words read back as a per-index pattern.
    logic [127:0] mem [256];
    logic [255:0] written = '0;
    always @(posedge clk) begin
        if (dm_ctrl_sig == WST) begin
            mem[mem_ctrl_addr[31:24]]     <= dm_wdata;
            written[mem_ctrl_addr[31:24]] <= 1'b1;
        end else if (dm_ctrl_sig == WLD) begin
            dm_rdata <= written[mem_ctrl_addr[31:24]] ? mem[mem_ctrl_addr[31:24]]
                      : {4{32'hA5A5_0000 | {24'h0, mem_ctrl_addr[31:24]}}};
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [127:0] d);
        req_valid = 1'b1; req_op = WST; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        chk("st_cmd", dm_ctrl_sig, WST);
        chk("st_addr", mem_ctrl_addr, {a[7:0], 24'h0});
        chk("st_wdata", dm_wdata, d);
        chk("st_busy", req_ready, 1'b0);
        tick();
        chk("st_cmd_off", dm_ctrl_sig, NOP);
        chk("st_ready", req_ready, 1'b1);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [4:0] t,
                           input logic [127:0] exp, input logic exp_err, input int stall);
        req_valid = 1'b1; req_op = WLD; req_addr = a; req_tag = t;
        tick();
        req_valid = 1'b0;
        if (!exp_err) begin
            chk("ld_cmd", dm_ctrl_sig, WLD);
            chk("ld_addr", mem_ctrl_addr, {a[7:0], 24'h0});
            chk("ld_rv_e0", rsp_valid, 1'b0);
            tick();
            chk("ld_cmd_off", dm_ctrl_sig, NOP);
            chk("ld_rv_e1", rsp_valid, 1'b0);
            tick();
        end else begin
            chk("oor_cmd", dm_ctrl_sig, NOP);
            chk("oor_addr_err", addr_err, 1'b1);
        end
        chk("ld_rv", rsp_valid, 1'b1);
        chk("ld_data", rsp_data, exp);
        chk("ld_tag", rsp_tag, t);
        chk("ld_err", rsp_err, exp_err);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_rv", rsp_valid, 1'b1);
            chk("stall_data", rsp_data, exp);
            chk("stall_tag", rsp_tag, t);
            chk("stall_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ld_done_rv", rsp_valid, 1'b0);
        chk("ld_done_ready", req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d0;
        logic [127:0] d1;
        logic [127:0] d2;
        logic         seen;
        d0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        d1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        d2 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_5678;

        repeat (3) tick();
        req_valid = 1'b1; req_op = WST; req_addr = 32'h3;
        tick();
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_cmd", dm_ctrl_sig, NOP);
        chk("rst_addr", mem_ctrl_addr, 32'h0);
        chk("rst_wdata", dm_wdata, 128'h0);
        chk("rst_rv", rsp_valid, 1'b0);
        chk("rst_err", {rsp_err, addr_err}, 2'b00);
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        do_store(32'h05, d0);
        do_load(32'h05, 5'd3, d0, 1'b0, 0);

        do_load(32'hFF, 5'd9, {4{32'hA5A5_00FF}}, 1'b0, 4);

        req_valid = 1'b1; req_op = WST; req_addr = 32'h100; req_wdata = d2;
        tick();
        req_valid = 1'b0;
        chk("bad_st_err", addr_err, 1'b1);
        chk("bad_st_cmd", dm_ctrl_sig, NOP);
        chk("bad_st_ready", req_ready, 1'b1);
        tick();
        chk("bad_st_err_off", addr_err, 1'b0);
        chk("bad_st_cmd2", dm_ctrl_sig, NOP);
        do_load(32'h00, 5'd1, {4{32'hA5A5_0000}}, 1'b0, 0);

        do_load(32'h0001_0000, 5'd7, 128'h0, 1'b1, 0);

        req_valid = 1'b1; req_op = 2'b11; req_addr = 32'h7;
        tick();
        req_valid = 1'b0;
        chk("undef_cmd", dm_ctrl_sig, NOP);
        chk("undef_ready", req_ready, 1'b1);
        chk("undef_rv", rsp_valid, 1'b0);

        req_valid = 1'b1; req_op = WST; req_addr = 32'h10; req_wdata = d1;
        tick();
        chk("b2b_cmd0", dm_ctrl_sig, WST);
        chk("b2b_addr0", mem_ctrl_addr, 32'h1000_0000);
        req_addr = 32'h11; req_wdata = d2;
        tick();
        chk("b2b_gap_cmd", dm_ctrl_sig, NOP);
        chk("b2b_gap_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("b2b_cmd1", dm_ctrl_sig, WST);
        chk("b2b_addr1", mem_ctrl_addr, 32'h1100_0000);
        chk("b2b_wdata1", dm_wdata, d2);
        tick();
        do_load(32'h10, 5'd4, d1, 1'b0, 0);
        do_load(32'h11, 5'd5, d2, 1'b0, 0);

        req_valid = 1'b1; req_op = WLD; req_addr = 32'h20; req_tag = 5'd12;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_cmd", dm_ctrl_sig, NOP);
        chk("arst_addr", mem_ctrl_addr, 32'h0);
        chk("arst_ready", req_ready, 1'b1);
        chk("arst_rv", rsp_valid, 1'b0);
        chk("arst_data", rsp_data, 128'h0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        chk("arst_no_rsp", seen, 1'b0);
        chk("arst_ready_after", req_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
